// File: rtl/clks_div_gen.sv
// Cascaded clock divider: NUM_OUT registered clocks, each half the rate of the previous one, with a runtime half-period.
// Optional macro CLKS_DIV_GEN_DUTY_EN adds input duty_odd (odd half-periods: high div_cur cycles, low div_cur-1 cycles).
module clks_div_gen #(
   parameter int NUM_OUT     = 3,
   parameter int CNT_W       = 8,
   parameter int DIV_DEFAULT = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enb,
`ifdef CLKS_DIV_GEN_DUTY_EN
   input  logic               duty_odd,
`endif
   input  logic               div_req,
   input  logic [CNT_W-1:0]   div_val,
   output logic               div_busy,
   output logic               div_ack,
   output logic [CNT_W-1:0]   div_cur,
   output logic [NUM_OUT-1:0] clk_o,
   output logic [NUM_OUT-1:0] stb_o,
   output logic               frame_o
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   div_cur_q, div_cur_d;
   logic [CNT_W-1:0]   pend_q, pend_d;
   logic               busy_q, busy_d;
   logic               ack_q, ack_d;
   logic               frame_q, frame_d;
   logic [NUM_OUT-1:0] clk_q, clk_d;
   logic [NUM_OUT-1:0] stb_q, stb_d;

   logic [CNT_W-1:0]   thresh;
   logic [NUM_OUT-1:0] toggle;
   logic               tick;
   logic               frame_tick;
   logic               apply;

   always_comb begin
      thresh = div_cur_q - CNT_ONE;
`ifdef CLKS_DIV_GEN_DUTY_EN
      // Shorten the low phase by one cycle so an odd half-period keeps the extra cycle high.
      if (duty_odd && div_cur_q[0] && (div_cur_q > CNT_ONE) && !clk_q[0])
         thresh = div_cur_q - CNT_TWO;
`endif
      tick       = enb && (cnt_q >= thresh);
      frame_tick = tick && (clk_q == '0);
      apply      = frame_tick && busy_q;

      // Output i toggles only when every faster output is currently low.
      toggle    = '0;
      toggle[0] = 1'b1;
      for (int i = 1; i < NUM_OUT; i++)
         toggle[i] = toggle[i-1] && !clk_q[i-1];

      cnt_d     = cnt_q;
      div_cur_d = div_cur_q;
      pend_d    = pend_q;
      busy_d    = busy_q;
      ack_d     = 1'b0;
      frame_d   = 1'b0;
      clk_d     = clk_q;
      stb_d     = '0;

      if (tick) begin
         cnt_d   = '0;
         clk_d   = clk_q ^ toggle;
         stb_d   = toggle & ~clk_q;
         frame_d = frame_tick;
      end else if (enb) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (apply) begin
         div_cur_d = pend_q;
         busy_d    = 1'b0;
         ack_d     = 1'b1;
      end else if (div_req && !busy_q) begin
         pend_d = (div_val == '0) ? CNT_ONE : div_val;
         busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= DIV_RST - CNT_ONE;
         div_cur_q <= DIV_RST;
         pend_q    <= '0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         frame_q   <= 1'b0;
         clk_q     <= '0;
         stb_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         div_cur_q <= div_cur_d;
         pend_q    <= pend_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         frame_q   <= frame_d;
         clk_q     <= clk_d;
         stb_q     <= stb_d;
      end
   end

   assign div_busy = busy_q;
   assign div_ack  = ack_q;
   assign div_cur  = div_cur_q;
   assign clk_o    = clk_q;
   assign stb_o    = stb_q;
   assign frame_o  = frame_q;

endmodule
